// File: rtl/mem_ctrl.sv
// Arbitrates the LSB and fetch ports onto one byte-wide RAM/IO port, one access at a time.
// Reads complete n+2 cycles after acceptance, stores n+1 (plus IO stall and rdy freeze cycles).
module mem_ctrl #(
  parameter int IF_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    if_en,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*IF_BYTES-1:0]   if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [2:0]              lsb_len,
  input  logic [31:0]             lsb_w_data,
  output logic                    lsb_done,
  output logic [31:0]             lsb_r_data,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int BW = (IF_BYTES > 4) ? 8 * IF_BYTES : 32;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t                  state, state_n;
  logic [4:0]              cnt, cnt_n;
  logic [4:0]              len, len_n;
  logic [31:0]             base, base_n;
  logic [31:0]             wdata, wdata_n;
  logic [BW-1:0]           rbuf, rbuf_n;
  logic [31:0]             a_n;
  logic [7:0]              dout_n;
  logic                    wr_q, wr_n;
  logic                    if_done_q, if_done_n;
  logic                    lsb_done_q, lsb_done_n;
  logic [8*IF_BYTES-1:0]   if_data_n;
  logic [31:0]             lsb_r_data_n;
  logic [7:0]              din_hold;
  logic                    use_hold;

  logic [7:0]              din_eff;
  logic [7:0]              sh_r;
  logic [7:0]              sh_w;
  logic [BW-1:0]           rd_merged;
  logic [31:0]             wdata_sh;
  logic [31:0]             nxt_addr;

  // A freeze lets the RAM move on to the next address, so the byte that was due
  // when rdy dropped is parked in din_hold and consumed on the first live edge.
  assign din_eff   = use_hold ? din_hold : mem_din;
  assign sh_r      = {cnt - 5'd1, 3'b000};
  assign sh_w      = {cnt + 5'd1, 3'b000};
  assign rd_merged = rbuf | ({{(BW-8){1'b0}}, din_eff} << sh_r);
  assign wdata_sh  = wdata >> sh_w;
  assign nxt_addr  = base + {27'b0, cnt} + 32'd1;

  assign mem_wr   = wr_q & rdy;
  assign if_done  = if_done_q & rdy;
  assign lsb_done = lsb_done_q & rdy;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    len_n        = len;
    base_n       = base;
    wdata_n      = wdata;
    rbuf_n       = rbuf;
    a_n          = mem_a;
    dout_n       = mem_dout;
    wr_n         = wr_q;
    if_done_n    = 1'b0;
    lsb_done_n   = 1'b0;
    if_data_n    = if_data;
    lsb_r_data_n = lsb_r_data;
    case (state)
      IDLE: begin
        wr_n = 1'b0;
        // The cycle carrying a done pulse still sees the old request's en high.
        if (!rollback && !if_done_q && !lsb_done_q) begin
          if (lsb_en) begin
            base_n  = lsb_addr;
            len_n   = {2'b00, lsb_len};
            wdata_n = lsb_w_data;
            cnt_n   = '0;
            a_n     = lsb_addr;
            rbuf_n  = '0;
            if (lsb_wr) begin
              state_n = STORE;
              dout_n  = lsb_w_data[7:0];
              wr_n    = !(lsb_addr[17:16] == 2'b11 && io_buffer_full);
            end else begin
              state_n = LOAD;
            end
          end else if (if_en) begin
            state_n = FETCH;
            base_n  = if_addr;
            len_n   = 5'(IF_BYTES);
            cnt_n   = '0;
            a_n     = if_addr;
            rbuf_n  = '0;
          end
        end
      end
      FETCH, LOAD: begin
        if (rollback) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          if (cnt != 5'd0) rbuf_n = rd_merged;
          if (cnt == len) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == FETCH) begin
              if_done_n = 1'b1;
              if_data_n = rd_merged[8*IF_BYTES-1:0];
            end else begin
              lsb_done_n   = 1'b1;
              lsb_r_data_n = rd_merged[31:0];
            end
          end else begin
            cnt_n = cnt + 5'd1;
            a_n   = nxt_addr;
          end
        end
      end
      STORE: begin
        if (wr_q) begin
          if (cnt == len - 5'd1) begin
            state_n    = IDLE;
            cnt_n      = '0;
            wr_n       = 1'b0;
            lsb_done_n = 1'b1;
          end else begin
            cnt_n  = cnt + 5'd1;
            a_n    = nxt_addr;
            dout_n = wdata_sh[7:0];
            wr_n   = !(nxt_addr[17:16] == 2'b11 && io_buffer_full);
          end
        end else begin
          wr_n = !(mem_a[17:16] == 2'b11 && io_buffer_full);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      base       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      if_data    <= '0;
      lsb_r_data <= '0;
      din_hold   <= '0;
      use_hold   <= 1'b0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      base       <= base_n;
      wdata      <= wdata_n;
      rbuf       <= rbuf_n;
      mem_a      <= a_n;
      mem_dout   <= dout_n;
      wr_q       <= wr_n;
      if_done_q  <= if_done_n;
      lsb_done_q <= lsb_done_n;
      if_data    <= if_data_n;
      lsb_r_data <= lsb_r_data_n;
      use_hold   <= 1'b0;
    end else if (!use_hold) begin
      din_hold <= mem_din;
      use_hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model (one-cycle read latency).
module tb_mem_ctrl;
  localparam int IFB = 4;

  logic            clk = 1'b0;
  logic            rst, rdy, rollback, if_en;
  logic [31:0]     if_addr;
  logic            if_done;
  logic [8*IFB-1:0] if_data;
  logic            lsb_en, lsb_wr;
  logic [31:0]     lsb_addr;
  logic [2:0]      lsb_len;
  logic [31:0]     lsb_w_data;
  logic            lsb_done;
  logic [31:0]     lsb_r_data;
  logic [7:0]      mem_din, mem_dout;
  logic [31:0]     mem_a;
  logic            mem_wr;
  logic            io_buffer_full;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int lsb_done_cnt = 0;
  int if_done_cnt = 0;

  logic [7:0] ram [0:65535];

  mem_ctrl #(.IF_BYTES(IFB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    ram[16'h0100] <= 8'h11; ram[16'h0101] <= 8'h22;
    ram[16'h0102] <= 8'h33; ram[16'h0103] <= 8'h44;
    ram[16'h0000] <= 8'hDE; ram[16'h0001] <= 8'hAD;
    ram[16'h0002] <= 8'hBE; ram[16'h0003] <= 8'hEF;
    ram[16'h0202] <= 8'h99; ram[16'hFFFF] <= 8'h3C;
  end

  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    if (lsb_done) lsb_done_cnt <= lsb_done_cnt + 1;
    if (if_done) if_done_cnt <= if_done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Issues one LSB request; lat is the done cycle relative to the request cycle (-1 on timeout).
  task automatic do_lsb(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output int pulses);
    @(posedge clk); #1;
    lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_w_data = wd; lsb_en = 1'b1;
    lat = -1; rd = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (lsb_done) begin
        lat = c;
        rd  = lsb_r_data;
        break;
      end
    end
    @(posedge clk); #1 lsb_en = 1'b0;
    pulses = (lat >= 0) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (lsb_done) pulses++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %h want 0", mem_wr); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %h want 0", if_done); end
    checks++; if (lsb_done !== 1'b0) begin errors++; $display("FAIL reset_lsb_done got %h want 0", lsb_done); end
    checks++; if (if_data !== '0) begin errors++; $display("FAIL reset_if_data got %h want 0", if_data); end
    checks++; if (lsb_r_data !== 32'h0) begin errors++; $display("FAIL reset_lsb_r_data got %h want 0", lsb_r_data); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_lw;
    int lat, p; logic [31:0] rd;
    do_lsb(1'b0, 32'h100, 3'd4, 32'h0, lat, rd, p);
    checks++; if (lat != 6) begin errors++; $display("FAIL lw_latency got %0d want 6", lat); end
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL lw_data got %h want 44332211", rd); end
    checks++; if (p != 1) begin errors++; $display("FAIL lw_pulses got %0d want 1", p); end
  endtask

  task automatic test_sb_lh;
    int lat, p, w0; logic [31:0] rd;
    w0 = wr_count;
    do_lsb(1'b1, 32'h200, 3'd1, 32'h12345678, lat, rd, p);
    checks++; if (lat != 2) begin errors++; $display("FAIL sb_latency got %0d want 2", lat); end
    checks++; if (p != 1) begin errors++; $display("FAIL sb_pulses got %0d want 1", p); end
    checks++; if (ram[16'h0200] !== 8'h78) begin errors++; $display("FAIL sb_byte0 got %h want 78", ram[16'h0200]); end
    checks++; if (ram[16'h0201] !== 8'h00) begin errors++; $display("FAIL sb_byte1_untouched got %h want 00", ram[16'h0201]); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL sb_write_count got %0d want 1", wr_count - w0); end
    do_lsb(1'b0, 32'h200, 3'd2, 32'h0, lat, rd, p);
    checks++; if (rd !== 32'h00000078) begin errors++; $display("FAIL lh_data got %h want 00000078", rd); end
    checks++; if (lat != 4) begin errors++; $display("FAIL lh_latency got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back;
    int ld, fd, f0; logic [31:0] lr; logic [8*IFB-1:0] fdat;
    ld = -1; fd = -1; lr = '0; fdat = '0;
    f0 = if_done_cnt;
    @(posedge clk); #1;
    lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd1; lsb_en = 1'b1;
    if_addr = 32'h0; if_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (lsb_done) begin ld = c; lr = lsb_r_data; end
      if (if_done) begin fd = c; fdat = if_data; end
      if (fd >= 0) break;
      @(posedge clk); #1;
      if (ld >= 0) lsb_en = 1'b0;
    end
    @(posedge clk); #1 if_en = 1'b0; lsb_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ld != 3) begin errors++; $display("FAIL b2b_lsb_cycle got %0d want 3", ld); end
    checks++; if (lr !== 32'h00000011) begin errors++; $display("FAIL b2b_lsb_data got %h want 00000011", lr); end
    checks++; if (fd != 4 + IFB + 2) begin errors++; $display("FAIL b2b_fetch_cycle got %0d want %0d", fd, 4 + IFB + 2); end
    checks++; if (fdat !== 32'hEFBEADDE) begin errors++; $display("FAIL b2b_fetch_data got %h want efbeadde", fdat); end
    checks++; if (if_done_cnt - f0 != 1) begin errors++; $display("FAIL b2b_fetch_pulses got %0d want 1", if_done_cnt - f0); end
  endtask

  task automatic test_wrap;
    int lat, p; logic [31:0] rd;
    fork
      do_lsb(1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0, lat, rd, p);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 00000000", mem_a); end
      end
    join
    checks++; if (rd !== 32'h0000DE3C) begin errors++; $display("FAIL wrap_data got %h want 0000de3c", rd); end
    checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", lat); end
  endtask

  task automatic test_rollback;
    int lat, p, f0, w0; logic [31:0] rd;
    f0 = if_done_cnt;
    @(posedge clk); #1 if_addr = 32'h100; if_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rollback = 1'b1; if_en = 1'b0;
    fork
      begin @(posedge clk); #1 rollback = 1'b0; end
      do_lsb(1'b0, 32'h103, 3'd1, 32'h0, lat, rd, p);
    join
    checks++; if (lat != 3) begin errors++; $display("FAIL rb_fetch_idle_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'h00000044) begin errors++; $display("FAIL rb_followup_data got %h want 00000044", rd); end
    checks++; if (if_done_cnt - f0 != 0) begin errors++; $display("FAIL rb_fetch_no_done got %0d want 0", if_done_cnt - f0); end
    w0 = wr_count;
    fork
      do_lsb(1'b1, 32'h300, 3'd4, 32'hA1B2C3D4, lat, rd, p);
      begin
        repeat (3) @(posedge clk);
        #1 rollback = 1'b1;
        @(posedge clk); #1 rollback = 1'b0;
      end
    join
    checks++; if (lat != 5) begin errors++; $display("FAIL rb_sw_latency got %0d want 5", lat); end
    checks++; if (p != 1) begin errors++; $display("FAIL rb_sw_pulses got %0d want 1", p); end
    checks++; if ({ram[16'h0303], ram[16'h0302], ram[16'h0301], ram[16'h0300]} !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL rb_sw_bytes got %h want a1b2c3d4",
                         {ram[16'h0303], ram[16'h0302], ram[16'h0301], ram[16'h0300]});
    end
    checks++; if (wr_count - w0 != 4) begin errors++; $display("FAIL rb_sw_writes got %0d want 4", wr_count - w0); end
  endtask

  task automatic test_io_stall;
    int lat, p, w0, low; logic [31:0] rd;
    w0 = wr_count; low = 0;
    fork
      do_lsb(1'b1, 32'h0003_0000, 3'd1, 32'h0000005A, lat, rd, p);
      begin
        @(posedge clk); #1 io_buffer_full = 1'b1;
        @(posedge clk);
        @(negedge clk); if (!mem_wr) low++;
        @(posedge clk);
        @(negedge clk); if (!mem_wr) low++;
        @(posedge clk); #1 io_buffer_full = 1'b0;
        @(negedge clk); if (!mem_wr) low++;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL io_resume_wr got %h want 1", mem_wr); end
        checks++; if (low != 3) begin errors++; $display("FAIL io_stall_cycles got %0d want 3", low); end
      end
    join
    checks++; if (lat != 5) begin errors++; $display("FAIL io_latency got %0d want 5", lat); end
    checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL io_writes got %0d want 1", wr_count - w0); end
    checks++; if (ram[16'h0000] !== 8'h5A) begin errors++; $display("FAIL io_byte got %h want 5a", ram[16'h0000]); end
  endtask

  task automatic test_rdy_freeze;
    int lat, p; logic [31:0] rd;
    fork
      do_lsb(1'b0, 32'h100, 3'd4, 32'h0, lat, rd, p);
      begin
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    checks++; if (lat != 8) begin errors++; $display("FAIL freeze_latency got %0d want 8", lat); end
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL freeze_data got %h want 44332211", rd); end
    checks++; if (p != 1) begin errors++; $display("FAIL freeze_pulses got %0d want 1", p); end
  endtask

  task automatic test_rst_mid;
    int w0, d0;
    w0 = wr_count; d0 = lsb_done_cnt;
    @(posedge clk); #1;
    lsb_wr = 1'b1; lsb_addr = 32'h400; lsb_len = 3'd4; lsb_w_data = 32'h01020304; lsb_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; lsb_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_wr got %h want 0", mem_wr); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_mid_mem_a got %h want 0", mem_a); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if ({ram[16'h0402], ram[16'h0401], ram[16'h0400]} !== 24'h000304) begin
      errors++; $display("FAIL rst_mid_bytes got %h want 000304", {ram[16'h0402], ram[16'h0401], ram[16'h0400]});
    end
    checks++; if (wr_count - w0 != 2) begin errors++; $display("FAIL rst_mid_writes got %0d want 2", wr_count - w0); end
    checks++; if (lsb_done_cnt - d0 != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", lsb_done_cnt - d0); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_en = 1'b0; if_addr = '0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
    io_buffer_full = 1'b0;
    test_reset;
    test_lw;
    test_sb_lh;
    test_back_to_back;
    test_wrap;
    test_rollback;
    test_io_stall;
    test_rdy_freeze;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
